// File: rtl/mux2_3bit_if.sv
`default_nettype none
// ============================================================================
// Module      : mux2_3bit_if
// Description : Bus bundle for the 3-bit 2:1 datapath multiplexer. The master
//               side drives the two operands and the select; the slave side
//               (the mux) returns the combinational and registered results.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux2_3bit_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;

  // Producer of operands / consumer of results (decode/control side)
  modport master (
    output in0,
    output in1,
    output sel,
    input  out,
    input  out_q
  );

  // The multiplexer itself
  modport slave (
    input  in0,
    input  in1,
    input  sel,
    output out,
    output out_q
  );
endinterface
`default_nettype wire

// File: rtl/mux2_3bit.sv
`default_nettype none
// ============================================================================
// Module      : mux2_3bit
// Description : 2:1 multiplexer for 3-bit CPU datapath fields. Provides a
//               zero-latency combinational result for same-cycle use and a
//               one-cycle registered copy for pipelined consumers.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_3bit #(
  parameter int WIDTH = 3
) (
  input  wire          clk,
  input  wire          rst_n,
  mux2_3bit_if.slave   bus
);

  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] out_q;

  // Continuous assignment keeps plain ?: semantics, so an unknown select
  // yields X only on bits where the two operands disagree.
  assign mux_d = bus.sel ? bus.in1 : bus.in0;

  // Combinational result; never touched by clk or rst_n
  assign bus.out = mux_d;

  // Registered copy; reset clears it immediately, independent of clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= mux_d;
    end
  end

  assign bus.out_q = out_q;

endmodule
`default_nettype wire

// File: tb/tb_mux2_3bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux2_3bit
// Description : Self-checking bench for mux2_3bit. Directed steps followed by
//               an exhaustive sweep and random vectors, checked against a
//               table-lookup reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2_3bit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [2:0] exp_q;

  mux2_3bit_if #(.WIDTH(3)) bus ();

  mux2_3bit #(.WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: pick operand from a two-entry table indexed by the select
  function automatic logic [2:0] ref_mux(input logic [2:0] a,
                                         input logic [2:0] b,
                                         input logic       s);
    logic [2:0] choice [2];
    choice[0] = a;
    choice[1] = b;
    return choice[s];
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs,
                     input logic [2:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive operands right after a falling edge, away from the capture edge
  task automatic drive(input logic [2:0] a, input logic [2:0] b,
                       input logic s);
    @(negedge clk);
    bus.in0 = a;
    bus.in1 = b;
    bus.sel = s;
    #1;
  endtask

  task automatic after_rise();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n   = 1'b0;
    bus.in0 = 3'b000;
    bus.in1 = 3'b000;
    bus.sel = 1'b0;
    exp_q   = 3'b000;

    // Reset state
    #2;
    chk("reset_out_q", bus.out_q, 3'b000);
    chk("reset_out", bus.out, 3'b000);

    // Registered output must hold 0 across edges while reset is low,
    // while the combinational path keeps working
    drive(3'b110, 3'b011, 1'b1);
    chk("reset_out_live", bus.out, ref_mux(3'b110, 3'b011, 1'b1));
    after_rise();
    chk("reset_hold_q", bus.out_q, 3'b000);

    // Release reset; nothing captured until the next rising edge
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_q_before_edge", bus.out_q, 3'b000);

    // Combinational select, first data set
    drive(3'b000, 3'b001, 1'b0);
    chk("comb_a_sel0", bus.out, 3'b000);
    bus.sel = 1'b1;
    #1;
    chk("comb_a_sel1", bus.out, 3'b001);

    // Combinational select, second data set, held and re-sampled for 20 ns
    drive(3'b100, 3'b111, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("comb_b_sel0_hold", bus.out, 3'b100);
      #5;
    end
    bus.sel = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("comb_b_sel1_hold", bus.out, 3'b111);
      #5;
    end

    // Registered path: select toggles 0,1,0 on successive cycles
    drive(3'b100, 3'b111, 1'b0);
    after_rise();
    chk("reg_seq0", bus.out_q, 3'b100);
    drive(3'b100, 3'b111, 1'b1);
    after_rise();
    chk("reg_seq1", bus.out_q, 3'b111);
    drive(3'b100, 3'b111, 1'b0);
    after_rise();
    chk("reg_seq2", bus.out_q, 3'b100);

    // Asynchronous reset between clock edges
    drive(3'b100, 3'b111, 1'b1);
    after_rise();
    chk("pre_async_q", bus.out_q, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear_q", bus.out_q, 3'b000);
    chk("async_out_kept", bus.out, 3'b111);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("async_release_wait", bus.out_q, 3'b000);
    after_rise();
    chk("async_recapture", bus.out_q, 3'b111);

    // Exhaustive sweep of every operand/select combination
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int s = 0; s < 2; s++) begin
          drive(3'(a), 3'(b), 1'(s));
          exp_q = ref_mux(3'(a), 3'(b), 1'(s));
          chk("sweep_out", bus.out, exp_q);
          after_rise();
          chk("sweep_out_q", bus.out_q, exp_q);
        end
      end
    end

    // Random vectors with occasional mid-operation resets
    for (int n = 0; n < 200; n++) begin
      logic [2:0] ra;
      logic [2:0] rb;
      logic       rs;
      ra = 3'($urandom_range(7));
      rb = 3'($urandom_range(7));
      rs = 1'($urandom_range(1));
      drive(ra, rb, rs);
      chk("rand_out", bus.out, ref_mux(ra, rb, rs));
      if ($urandom_range(15) == 0) begin
        rst_n = 1'b0;
        #1;
        exp_q = 3'b000;
        chk("rand_reset_q", bus.out_q, exp_q);
        chk("rand_reset_out", bus.out, ref_mux(ra, rb, rs));
        after_rise();
        chk("rand_reset_hold", bus.out_q, exp_q);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
      end else begin
        exp_q = ref_mux(ra, rb, rs);
        after_rise();
        chk("rand_out_q", bus.out_q, exp_q);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
